// File: rtl/if_fetch_if.sv
// Byte-wide instruction memory read port used by the fetch stage.
// The fetch stage is the master; the memory (or its model) is the slave.
interface if_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// RV32I instruction fetch: builds each word from four byte reads, then predicts the next PC
// with a 2-bit saturating-counter BHT (B-type) or always-taken (JAL).
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned BR_INDEX_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_in,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  input  logic                  upd_en,
  input  logic [BR_INDEX_W-1:0] upd_index,
  input  logic                  upd_taken,
  if_fetch_if.master            mem,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_inst,
  output logic [BR_INDEX_W-1:0] if_br_index,
  output logic                  if_prd_jmp,
  output logic                  if_stall_req
);

  localparam int BhtDepth = 2 ** BR_INDEX_W;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // F0..F3 encode the byte number in their low two bits.
  typedef enum logic [2:0] {
    StF0  = 3'd0,
    StF1  = 3'd1,
    StF2  = 3'd2,
    StF3  = 3'd3,
    StRdy = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           inst_q, inst_d;
  logic [1:0]            bht_q [BhtDepth];

  logic                  fetching;
  logic [1:0]            byte_sel;
  logic [BR_INDEX_W-1:0] idx;
  logic [6:0]            opcode;
  logic [31:0]           imm_b, imm_j;
  logic [31:0]           target, next_pc;
  logic                  prd;
  logic [1:0]            cnt_cur, cnt_new;
  logic                  unused_rpc_low;

  assign fetching       = (state_q != StRdy);
  assign byte_sel       = state_q[1:0];
  assign idx            = pc_q[BR_INDEX_W+1:2];
  assign opcode         = inst_q[6:0];
  assign unused_rpc_low = ^redirect_pc[1:0];

  assign imm_b = {{20{inst_q[31]}}, inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_j = {{12{inst_q[31]}}, inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

  always_comb begin
    prd    = 1'b0;
    target = pc_q + imm_j;
    case (opcode)
      OpBranch: begin
        prd    = bht_q[idx][1];
        target = pc_q + imm_b;
      end
      OpJal: begin
        prd    = 1'b1;
        target = pc_q + imm_j;
      end
      default: prd = 1'b0;
    endcase
    next_pc = prd ? target : pc_q + 32'd4;
  end

  // Presented fields are forced to zero while the word is still being assembled.
  always_comb begin
    if_stall_req = fetching;
    if_pc        = fetching ? 32'd0 : pc_q;
    if_inst      = fetching ? 32'd0 : inst_q;
    if_br_index  = fetching ? '0 : idx;
    if_prd_jmp   = fetching ? 1'b0 : prd;
  end

  assign mem.mem_req  = fetching && !rst && !redirect;
  assign mem.mem_addr = pc_q + {30'd0, byte_sel};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (redirect) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = StF0;
    end else begin
      unique case (state_q)
        StF0, StF1, StF2, StF3: begin
          if (mem.mem_ack) begin
            inst_d[{byte_sel, 3'b000} +: 8] = mem.mem_rdata;
            state_d = (state_q == StF3) ? StRdy : state_e'(state_q + 3'd1);
          end
        end
        StRdy: begin
          if (!stall_in) begin
            pc_d    = next_pc;
            state_d = StF0;
          end
        end
        default: state_d = StF0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StF0;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    cnt_cur = bht_q[upd_index];
    if (upd_taken) begin
      cnt_new = (cnt_cur == 2'b11) ? 2'b11 : cnt_cur + 2'b01;
    end else begin
      cnt_new = (cnt_cur == 2'b00) ? 2'b00 : cnt_cur - 2'b01;
    end
  end

  // Same-cycle lookups read bht_q, so they see the pre-update counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BhtDepth; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (upd_en) begin
      bht_q[upd_index] <= cnt_new;
    end
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the RV32I pipeline; drives the IF/ID pipeline register.
- Assembles each 32-bit instruction from four byte reads on a byte-wide memory port.
- Holds the PC and predicts the next PC with a 2-bit-counter BHT: B-type uses the counter, JAL is always taken.
- Supplies pc, inst, BHT index and prediction bit downstream; accepts mispredict redirects and BHT updates from EX.

Parameters:
- RESET_PC, 32'h0, PC loaded on reset.
- BR_INDEX_W, 7, BHT index width; the BHT has 2^BR_INDEX_W entries and the index equals pc[BR_INDEX_W+1:2].

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall_in  in  1  downstream hold; ready instruction must not advance.
- redirect  in  1  EX mispredict; restart fetch at redirect_pc.
- redirect_pc  in  32  corrected PC; bits [1:0] ignored and forced to 0.
- upd_en  in  1  BHT update strobe from EX (resolved B-type).
- upd_index  in  BR_INDEX_W  BHT entry to update.
- upd_taken  in  1  resolved outcome.
- mem_req  out  1  byte read request.
- mem_addr  out  32  byte address.
- mem_ack  in  1  mem_rdata valid this cycle; completes current request.
- mem_rdata  in  8  read byte.
- if_pc  out  32  PC of presented instruction.
- if_inst  out  32  presented instruction.
- if_br_index  out  BR_INDEX_W  BHT index of if_pc.
- if_prd_jmp  out  1  predicted taken.
- if_stall_req  out  1  instruction not ready; controller must stall or bubble IF/ID.

Behaviour:
- States: F0, F1, F2, F3 fetch byte k; RDY holds the assembled word.
- Reset:
  - pc=RESET_PC, state F0, inst_buf=0.
  - All BHT entries = 2'b01 (weakly not taken).
  - mem_req=0 during the reset cycle.
- Fk:
  - mem_req=1, mem_addr=pc+k.
  - On mem_ack: inst_buf[8k+7:8k] <= mem_rdata, advance to F(k+1), or to RDY after F3.
  - Without ack: hold state and address.
  - Little-endian assembly.
- Latency: minimum 4 cycles from entering F0 to RDY (ack every cycle); the instruction is presented in cycle 5.
- if_stall_req=1 in F0-F3 and 0 in RDY.
- if_pc, if_inst, if_br_index, if_prd_jmp:
  - Valid only in RDY.
  - if_pc and if_inst are registered.
  - if_br_index and if_prd_jmp are combinational from inst_buf and BHT.
  - In F0-F3 all four outputs are driven 0.
- Prediction in RDY (opcode = inst[6:0]):
  - 1100011 (B): prd = BHT[idx][1]; target = pc + imm_b, imm_b = sext{i[31],i[7],i[30:25],i[11:8],0}.
  - 1101111 (JAL): prd = 1; target = pc + imm_j, imm_j = sext{i[31],i[19:12],i[20],i[30:21],0}.
  - Otherwise: prd = 0.
  - next_pc = prd ? target : pc+4. All adds are mod 2^32; wrap is legal.
- RDY and stall_in=0: pc <= next_pc, go to F0. RDY and stall_in=1: hold everything.
- Redirect (priority below rst, above all else):
  - pc <= {redirect_pc[31:2],2'b00}, state F0.
  - mem_req=0 that cycle; any mem_ack that cycle is ignored and the partial word is discarded.
  - Applies in any state, including RDY with stall_in=1.
- BHT update:
  - upd_en: saturating counter, +1 if upd_taken, -1 otherwise, bounded 00..11.
  - Independent of state, redirect and stall; blocked only by rst.
  - An update and a lookup of the same index in the same cycle: the lookup sees the old value.
- mem_ack outside F0-F3: ignored.
- Reset mid-fetch: abandon immediately, restart at RESET_PC.

Test Plan:
- Reset, mem acks every cycle with memory holding 0x00000013 at 0 -> mem_addr 0,1,2,3 on four consecutive cycles; cycle 5: if_stall_req=0, if_pc=0, if_inst=0x00000013, if_prd_jmp=0; next fetch at 4.
- Word at 0x10 = 0x0080006F (JAL +8), no stall -> if_prd_jmp=1, if_br_index=4; next mem_addr=0x18.
- BEQ 0xFE000EE3 at 0x20, BHT default -> prd=0, next 0x24; after two upd_en taken at index 8 -> refetch gives prd=1, next 0x20+(-4)=0x1C; third taken keeps 11, and one not-taken -> 10, still predicted taken.
- RDY with stall_in=1 for 3 cycles -> outputs stable, no mem_req; release -> F0 at next_pc.
- Redirect to 0x103 asserted in F2 with mem_ack high -> byte dropped, mem_req=0 that cycle; next cycle mem_addr=0x100.
- mem_ack withheld 5 cycles in F1 -> mem_addr holds pc+1, if_stall_req stays 1; rst asserted in F2 -> next cycle F0 at RESET_PC, all BHT entries read 01.
